// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// status-word bit positions and default bus addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_BUSY   = 3;
  localparam int ST_CNT_LO = 4;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0030;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0130;

  // Occupancy field in the status word is only four bits wide.
  function automatic logic [3:0] sat_count(input int unsigned c);
    logic [31:0] v;
    v = c;
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// Processor I/O bus request lines (address and write strobe) seen by the UART.
interface uart_tx_controller_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] address;
  logic             wrtEn;

  modport master (output address, output wrtEn);
  modport slave  (input  address, input  wrtEn);
endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead output; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and resetting a RAM blocks RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_controller.sv
// Bus responder for the serial transmitter: address decode, status read-back
// on the shared tri-state bus, sticky overrun flag and the 8N1 shifter.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] DATA_ADDR  = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0] CTRL_ADDR  = DBITS'(DEF_CTRL_ADDR),
  parameter int               CLKDIV     = 434,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_controller_if.slave   bus,
  inout  wire  [DBITS-1:0]      dbus,
  output logic                  txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overrun;

  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  logic             wr_data, wr_ctrl, dbus_oe, bit_end;
  logic [DBITS-1:0] status;

  assign wr_data  = bus.wrtEn && (bus.address == DATA_ADDR);
  assign wr_ctrl  = bus.wrtEn && (bus.address == CTRL_ADDR);
  assign dbus_oe  = !bus.wrtEn &&
                    ((bus.address == DATA_ADDR) || (bus.address == CTRL_ADDR));
  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign bit_end  = (baud == BW'(CLKDIV - 1));

  // Only the low byte and the overrun-clear bit carry meaning on writes.
  wire unused_dbus_hi = ^dbus[DBITS-1:8];

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .din   (dbus[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // NOTE: combinational logic uses blocking assignments with a default first
  // so every path assigns every bit and no latch is inferred.
  always_comb begin
    status                     = '0;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_FULL]            = fifo_full;
    status[ST_OVR]             = overrun;
    status[ST_BUSY]            = (state != IDLE);
    status[ST_CNT_LO +: 4]     = sat_count(32'(fifo_count));
  end

  assign dbus = dbus_oe ? status : 'z;

  // A full FIFO that is popping on this edge still accepts the store.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      overrun <= 1'b1;
    end else if (wr_ctrl && !dbus[ST_OVR]) begin
      overrun <= 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (fifo_pop) begin
            shift <= fifo_dout;
            baud  <= '0;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed self-checking bench for uart_tx_controller with CLKDIV=4, depth 8.
module tb_uart_tx_controller;
  import uart_pkg::*;

  localparam int          CLKDIV = 4;
  localparam logic [31:0] DADDR  = 32'hF000_0030;
  localparam logic [31:0] CADDR  = 32'hF000_0130;

  logic        clk = 1'b0;
  logic        reset;
  logic        txd;
  logic [31:0] tb_dout;
  logic        tb_drive;
  wire  [31:0] dbus;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_controller_if #(.DBITS(32)) bus ();

  assign dbus = tb_drive ? tb_dout : 'z;

  uart_tx_controller #(
    .DBITS(32), .DATA_ADDR(DADDR), .CTRL_ADDR(CADDR),
    .CLKDIV(CLKDIV), .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbus  (dbus),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.wrtEn   = 1'b1;
    bus.address = addr;
    tb_dout     = data;
    tb_drive    = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    bus.wrtEn   = 1'b0;
    bus.address = addr;
    tb_drive    = 1'b0;
  endtask

  task automatic do_reset();
    bus_read(32'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  logic exp_line [81];
  bit   seen_idle;

  initial begin
    reset = 1'b0;
    bus_read(32'h0);
    tb_dout = '0;

    // Reset state and status read-back.
    do_reset();
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_oe_idle", 32'(dut.dbus_oe), 32'd0);
    bus_read(CADDR);
    #1 check("reset_status_ctrl", dbus, 32'h0000_0001);
    bus_read(DADDR);
    #1 check("reset_status_data", dbus, 32'h0000_0001);
    bus_read(32'hF000_0034);
    #1 check("other_addr_released", 32'(dut.dbus_oe), 32'd0);
    bus_write(CADDR, 32'h0);
    #1 check("write_released", 32'(dut.dbus_oe), 32'd0);
    bus_read(32'h0);

    // Single 0xA5 frame, 4 cycles per bit.
    bus_write(DADDR, 32'h0000_00A5);
    step();
    bus_read(CADDR);
    #1 check("a5_idle_txd", 32'(txd), 32'd1);
    check("a5_queued_status", dbus, 32'h0000_0010);
    step();
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) begin
        check($sformatf("a5_txd_bit%0d", k / 4), 32'(txd), 32'(frame_bit(8'hA5, k / 4)));
        check($sformatf("a5_busy_bit%0d", k / 4), 32'(dbus[3]), 32'd1);
      end
      step();
    end
    check("a5_done_status", dbus, 32'h0000_0001);
    check("a5_done_txd", 32'(txd), 32'd1);

    // Overrun: start one frame, then fill the FIFO and push one more.
    do_reset();
    bus_write(DADDR, 32'h0000_0011);
    step();
    bus_read(CADDR);
    step();
    step();
    for (int i = 0; i < 9; i++) begin
      bus_write(DADDR, 32'h20 + 32'(i));
      step();
    end
    bus_read(CADDR);
    #1 check("ovr_set_status", dbus, 32'h0000_008E);
    bus_write(CADDR, 32'h0000_0004);
    step();
    bus_read(CADDR);
    #1 check("ovr_keep_status", dbus, 32'h0000_008E);
    bus_write(CADDR, 32'h0000_0000);
    step();
    bus_read(CADDR);
    #1 check("ovr_clear_status", dbus, 32'h0000_008A);

    // Store lands on the same edge as the pop of a full FIFO.
    seen_idle = 1'b0;
    for (int c = 0; c < 100 && !seen_idle; c++) begin
      if (dbus[3] == 1'b0) seen_idle = 1'b1;
      else step();
    end
    check("full_pop_reached_idle", 32'(seen_idle), 32'd1);
    check("full_idle_status", dbus, 32'h0000_0082);
    bus_write(DADDR, 32'h0000_0077);
    step();
    bus_read(CADDR);
    #1 check("full_pop_push_status", dbus, 32'h0000_008A);

    // Two back-to-back frames 0x00 then 0xFF.
    do_reset();
    for (int c = 0; c < 81; c++) begin
      if (c < 40)       exp_line[c] = frame_bit(8'h00, c / 4);
      else if (c == 40) exp_line[c] = 1'b1;
      else              exp_line[c] = frame_bit(8'hFF, (c - 41) / 4);
    end
    bus_write(DADDR, 32'h0000_0000);
    step();
    bus_write(DADDR, 32'h0000_00FF);
    step();
    bus_read(CADDR);
    for (int c = 0; c < 81; c++) begin
      check($sformatf("b2b_txd_c%0d", c), 32'(txd), 32'(exp_line[c]));
      step();
    end
    check("b2b_done_status", dbus, 32'h0000_0001);

    // Reset in the middle of data bit 3.
    do_reset();
    bus_write(DADDR, 32'h0000_00A5);
    step();
    bus_write(DADDR, 32'h0000_003C);
    step();
    bus_read(CADDR);
    for (int c = 0; c < 17; c++) step();
    check("mid_reset_pre_txd", 32'(txd), 32'd0);
    check("mid_reset_pre_busy", 32'(dbus[3]), 32'd1);
    reset = 1'b1;
    step();
    check("mid_reset_txd", 32'(txd), 32'd1);
    check("mid_reset_status", dbus, 32'h0000_0001);
    reset = 1'b0;
    step();
    check("post_reset_txd", 32'(txd), 32'd1);
    check("post_reset_status", dbus, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
